fsm_bit_serializer: RTL and testbench
=====================================

# fsm_bit_serializer

Parallel-to-serial bit source that feeds the single-bit `IN` input of the sequence-detector FSMs. It accepts a WIDTH-bit word through a valid/ready handshake. It then drives the word onto `Bit_Out` one bit at a time, holding each bit for DIV clocks so the downstream Moore detector samples every bit at least once. It also exposes its state on `Estado_Salida` for testbench visibility, matching the detector stage.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `DIV`, default 1: clocks per bit; must be ≥ 1.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- `Clk` input, 1 bit: single clock, rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `word_in` input, WIDTH bits: parallel word; sampled only on handshake.
- `word_valid` input, 1 bit: upstream has a word.
- `word_ready` output, 1 bit: serializer can accept a word.
- `Bit_Out` output, 1 bit: serial bit; connects to the detector's `IN`.
- `Bit_Valid` output, 1 bit: high while `Bit_Out` carries a payload bit.
- `Done` output, 1 bit: one-cycle pulse after the last bit.
- `Estado_Salida` output, 2 bits: current state, for TB checking.

## Operation
- States are encoded as follows:
  - IDLE = 2'b00
  - SHIFT = 2'b01
  - DONE = 2'b10
  - 2'b11 is unused and must recover to IDLE on the next clock.
- IDLE behaviour:
  - `word_ready`=1, `Bit_Out`=0, `Bit_Valid`=0, `Done`=0.
  - A handshake occurs when `word_valid` && `word_ready`. It loads the shift register from `word_in`, clears `div_cnt` and `bit_cnt`, and moves to SHIFT.
- SHIFT behaviour:
  - `word_ready`=0, `Bit_Valid`=1.
  - `Bit_Out` = the shift register's MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - `div_cnt` counts 0..DIV-1. At DIV-1 it wraps to 0, the register shifts by one, and `bit_cnt` increments.
  - When `bit_cnt`=WIDTH-1 and `div_cnt`=DIV-1, the next state is DONE.
- DONE behaviour: `Bit_Valid`=0, `Bit_Out`=0, `Done`=1 for exactly one cycle, then IDLE.
- `word_valid` outside IDLE is ignored. `word_in` is not sampled and no data is lost inside the block; upstream must hold its word until it sees `word_ready`.
- Reset:
  - Asserting `Reset` at any time, including mid-SHIFT, aborts the word.
  - All outputs and state go to IDLE values immediately.
  - No `Done` pulse is generated for the aborted word.
- Reset values: `word_ready`=1, `Bit_Out`=0, `Bit_Valid`=0, `Done`=0, `Estado_Salida`=2'b00.

## Timing
- Outputs are registered, except `word_ready`, which is decoded from the state register (1 iff state==IDLE).
- Latency: a handshake at cycle t puts the first bit on `Bit_Out` at cycle t+1.
- Bit k (k=0..WIDTH-1) is valid during cycles t+1+k·DIV through t+(k+1)·DIV.
- `Done` is high at cycle t+WIDTH·DIV+1; `word_ready` returns at cycle t+WIDTH·DIV+2.
- Throughput: one word per WIDTH·DIV+2 cycles. Back-to-back words are separated by exactly one IDLE cycle with `Bit_Out`=0.
- With DIV=1, bits appear on consecutive cycles and `div_cnt` is constant 0.
- Counter widths are `$clog2(DIV)` (minimum 1) and `$clog2(WIDTH)`. There is no overflow beyond the terminal values.

## Structure
- Shared package `fsm_pkg` holds:
  - the state typedef and the IDLE/SHIFT/DONE constants;
  - the 2-bit `Estado_Salida` width, shared with the detector FSMs.
- One natural sub-module: `bit_period_counter` (DIV-modulo counter with terminal-count output). It is reused later for detector sampling.
- The shift register and bit counter stay in the top module.

## Test plan
- Reset: hold `Reset`=1 → `word_ready`=1, `Bit_Out`=0, `Bit_Valid`=0, `Done`=0, `Estado_Salida`=00.
- DIV=1, MSB_FIRST=1, word 8'hA5 → `Bit_Out` = 1,0,1,0,0,1,0,1 on cycles t+1..t+8, `Done` at t+9, `word_ready` at t+10.
- DIV=4, word 8'h81 → `Bit_Out`=1 for 4 cycles, then 0 for 24 cycles, then 1 for 4 cycles. `Done` at t+33.
- MSB_FIRST=0, word 8'h05 → bits 1,0,1,0,0,0,0,0. Feeding these into the 101 detector gives exactly one detection, at the third bit.
- `word_valid` pulsed with 8'hFF during SHIFT of 8'h00 → output stays all zeros and 8'hFF is not sent.
- `Reset` asserted at bit 3 of 8'hF0 → outputs reach IDLE values at once, with no `Done` pulse. After release, a new word 8'h3C serializes correctly from bit 0.

Source files
------------

// File: rtl/fsm_pkg.sv
// ============================================================================
// Module : fsm_pkg
// Brief  : State encoding and widths shared by the serializer and detector FSMs
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_pkg;

    localparam int ESTADO_W = 2;

    // 2'b11 is deliberately left unencoded; the FSMs fall back to IDLE from it.
    typedef enum logic [ESTADO_W-1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage : fsm_pkg

`default_nettype wire

// File: rtl/fsm_bit_serializer_if.sv
// ============================================================================
// Module : fsm_bit_serializer_if
// Brief  : Word handshake in, serial bit stream and status out
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_bit_serializer_if
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0]    word_in;
    logic                word_valid;
    logic                word_ready;
    logic                Bit_Out;
    logic                Bit_Valid;
    logic                Done;
    logic [ESTADO_W-1:0] Estado_Salida;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  Bit_Out,
        input  Bit_Valid,
        input  Done,
        input  Estado_Salida
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output Bit_Out,
        output Bit_Valid,
        output Done,
        output Estado_Salida
    );

endinterface : fsm_bit_serializer_if

`default_nettype wire

// File: rtl/bit_period_counter.sv
// ============================================================================
// Module : bit_period_counter
// Brief  : Modulo-DIV counter with terminal-count flag
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_period_counter #(
    parameter int DIV = 1
) (
    input  wire logic Clk,
    input  wire logic Reset,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      tc_o
);

    localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  c_TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == c_TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == c_TERM);

endmodule : bit_period_counter

`default_nettype wire

// File: rtl/fsm_bit_serializer.sv
// ============================================================================
// Module : fsm_bit_serializer
// Brief  : Parallel word to serial bit source, each bit held DIV clocks
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_bit_serializer
    import fsm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    fsm_bit_serializer_if.slave bus
);

    localparam int            BW     = $clog2(WIDTH);
    localparam logic [BW-1:0] c_LAST = BW'(WIDTH - 1);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
    logic             bit_valid_q, bit_valid_d;
    logic             done_q,      done_d;

    logic             w_tc;
    logic             w_in_shift;
    logic             w_bit;
    logic [WIDTH-1:0] w_shifted;

    assign w_in_shift = (state_q == SHIFT);

    bit_period_counter #(
        .DIV (DIV)
    ) u_period (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i (!w_in_shift),
        .en_i  (w_in_shift),
        .tc_o  (w_tc)
    );

    // Zeros are shifted in, so the register is empty once the last bit is out
    // and Bit_Out reads 0 in DONE/IDLE without extra gating.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_bit     = shreg_q[WIDTH-1];
            assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_bit     = shreg_q[0];
            assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                if (bus.word_valid) begin
                    shreg_d = bus.word_in;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tc) begin
                    shreg_d = w_shifted;
                    if (bit_cnt_q == c_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
        bit_valid_d = (state_d == SHIFT);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.word_ready    = (state_q == IDLE);
    assign bus.Bit_Out       = w_bit;
    assign bus.Bit_Valid     = bit_valid_q;
    assign bus.Done          = done_q;
    assign bus.Estado_Salida = state_q;

endmodule : fsm_bit_serializer

`default_nettype wire

// File: tb/tb_fsm_bit_serializer.sv
// ============================================================================
// Module : tb_fsm_bit_serializer
// Brief  : Scoreboard bench for two serializer configurations
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_bit_serializer;

    localparam int W  = 8;
    localparam int D0 = 1;
    localparam int M0 = 1;
    localparam int D1 = 4;
    localparam int M1 = 0;

    typedef struct {
        int cyc;
        bit b;
        bit done;
    } exp_t;

    logic         Clk;
    logic         Reset;
    logic         vld [2];
    logic [W-1:0] wrd [2];
    logic         rdy [2];
    logic         bo  [2];
    logic         bv  [2];
    logic         dn  [2];
    logic [1:0]   st  [2];

    exp_t expq [2][$];
    int   free_at [2];
    int   cyc;
    int   n_checks;
    int   n_fail;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        fsm_bit_serializer_if #(.WIDTH(W)) bus ();

        assign bus.word_in    = wrd[gi];
        assign bus.word_valid = vld[gi];
        assign rdy[gi]        = bus.word_ready;
        assign bo[gi]         = bus.Bit_Out;
        assign bv[gi]         = bus.Bit_Valid;
        assign dn[gi]         = bus.Done;
        assign st[gi]         = bus.Estado_Salida;

        fsm_bit_serializer #(
            .WIDTH     (W),
            .DIV       ((gi == 0) ? D0 : D1),
            .MSB_FIRST ((gi == 0) ? M0 : M1)
        ) u_dut (
            .Clk   (Clk),
            .Reset (Reset),
            .bus   (bus)
        );
    end

    function automatic int div_of(int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic bit msbf_of(int i);
        return (i == 0) ? (M0 != 0) : (M1 != 0);
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, want %0h", name, i, cyc, act, exp);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    // Reference model + monitor: a handshake at cycle t yields bit k on
    // cycles t+1+k*DIV .. t+(k+1)*DIV, Done at t+W*DIV+1, ready at t+W*DIV+2.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        free_at  = '{0, 0};
        forever begin
            @(negedge Clk);
            for (int i = 0; i < 2; i++) begin
                exp_t       e;
                logic [1:0] exp_st;
                if (Reset) begin
                    expq[i].delete();
                    free_at[i] = 0;
                end
                exp_st = 2'b00;
                if (expq[i].size() > 0 && expq[i][0].cyc == cyc)
                    exp_st = expq[i][0].done ? 2'b10 : 2'b01;

                if (bv[i] || dn[i]) begin
                    if (expq[i].size() == 0) begin
                        chk("unexpected_output", i, {30'd0, bv[i], dn[i]}, 32'd0);
                    end else begin
                        e = expq[i].pop_front();
                        chk("out_cycle", i, cyc, e.cyc);
                        chk("done_flag", i, {31'd0, dn[i]}, {31'd0, e.done});
                        chk("valid_flag", i, {31'd0, bv[i]}, {31'd0, !e.done});
                        if (!e.done) chk("bit_value", i, {31'd0, bo[i]}, {31'd0, e.b});
                    end
                end else if (expq[i].size() > 0 && expq[i][0].cyc <= cyc) begin
                    e = expq[i].pop_front();
                    chk("missing_output", i, 32'd0, e.done ? 32'd2 : 32'd1);
                end
                if (!bv[i]) chk("idle_bit_out", i, {31'd0, bo[i]}, 32'd0);
                chk("word_ready", i, {31'd0, rdy[i]}, {31'd0, (cyc >= free_at[i])});
                chk("estado", i, {30'd0, st[i]}, {30'd0, exp_st});

                if (!Reset && vld[i] && cyc >= free_at[i]) begin
                    for (int k = 0; k < W; k++) begin
                        bit b;
                        b = msbf_of(i) ? wrd[i][W-1-k] : wrd[i][k];
                        for (int r = 0; r < div_of(i); r++)
                            expq[i].push_back('{cyc + 1 + k * div_of(i) + r, b, 1'b0});
                    end
                    expq[i].push_back('{cyc + W * div_of(i) + 1, 1'b0, 1'b1});
                    free_at[i] = cyc + W * div_of(i) + 2;
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send2(logic [W-1:0] w0, logic [W-1:0] w1);
        vld[0] = 1'b1; wrd[0] = w0;
        vld[1] = 1'b1; wrd[1] = w1;
        step(1);
        vld[0] = 1'b0;
        vld[1] = 1'b0;
    endtask

    initial begin
        Reset  = 1'b1;
        vld[0] = 1'b0; wrd[0] = '0;
        vld[1] = 1'b0; wrd[1] = '0;
        step(3);
        Reset = 1'b0;
        step(2);

        // A5 MSB-first at DIV=1, 81 at DIV=4
        send2(8'hA5, 8'h81);
        step(40);
        // 05 LSB-first on the DIV=4 unit
        send2(8'h05, 8'h05);
        step(40);
        // Word offered mid-SHIFT must be ignored
        send2(8'h00, 8'h00);
        step(2);
        vld[0] = 1'b1; wrd[0] = 8'hFF;
        vld[1] = 1'b1; wrd[1] = 8'hFF;
        step(1);
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        step(40);
        // Asynchronous abort at bit 3, then a fresh word
        send2(8'hF0, 8'hF0);
        step(3);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        send2(8'h3C, 8'h3C);
        step(40);

        // Randomised traffic, valid toggling regardless of ready
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 1) == 1);
                wrd[i] = W'($urandom);
            end
            step(1);
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fsm_bit_serializer

`default_nettype wire
